// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// Module  : control_sequencer
// Brief   : Moore-FSM control unit stepping fetch/execute phases T0..T7.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        R_out,
  output logic        PC_out,
  output logic        MDR_out,
  output logic        Zlo_out,
  output logic        C_out,
  output logic        Rin,
  output logic        MARin,
  output logic        Zlowin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  op_sel,
  output logic        run,
  output logic [3:0]  state_view
);

  localparam logic [3:0] c_st_rst  = 4'd0;
  localparam logic [3:0] c_st_t0   = 4'd1;
  localparam logic [3:0] c_st_t1   = 4'd2;
  localparam logic [3:0] c_st_t2   = 4'd3;
  localparam logic [3:0] c_st_t3   = 4'd4;
  localparam logic [3:0] c_st_t4   = 4'd5;
  localparam logic [3:0] c_st_t5   = 4'd6;
  localparam logic [3:0] c_st_t6   = 4'd7;
  localparam logic [3:0] c_st_t7   = 4'd8;
  localparam logic [3:0] c_st_halt = 4'd15;

  localparam logic [4:0] c_op_ld   = 5'b00000;
  localparam logic [4:0] c_op_ldi  = 5'b00001;
  localparam logic [4:0] c_op_st   = 5'b00010;
  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_addi = 5'b01100;
  localparam logic [4:0] c_op_andi = 5'b01101;
  localparam logic [4:0] c_op_ori  = 5'b01110;
  localparam logic [4:0] c_op_br   = 5'b10010;
  localparam logic [4:0] c_op_jr   = 5'b10100;
  localparam logic [4:0] c_op_halt = 5'b11010;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [4:0] w_opcode;
  logic       w_is_rtype;
  logic       w_is_imm;
  logic       w_is_ld;
  logic       w_is_st;
  logic       w_is_br;
  logic       w_is_jr;
  logic       w_is_halt;
  logic       w_addi_like;
  logic       w_is_mem;
  logic       w_has_t4;
  logic [4:0] w_imm_alu;

  assign w_opcode    = ir[31:27];
  assign w_is_rtype  = (w_opcode == c_op_add) || (w_opcode == c_op_sub) ||
                       (w_opcode == c_op_and) || (w_opcode == c_op_or);
  assign w_is_imm    = (w_opcode == c_op_addi) || (w_opcode == c_op_andi) ||
                       (w_opcode == c_op_ori)  || (w_opcode == c_op_ldi);
  assign w_is_ld     = (w_opcode == c_op_ld);
  assign w_is_st     = (w_opcode == c_op_st);
  assign w_is_br     = (w_opcode == c_op_br);
  assign w_is_jr     = (w_opcode == c_op_jr);
  assign w_is_halt   = (w_opcode == c_op_halt);
  assign w_is_mem    = w_is_ld || w_is_st;
  // ld/st compute their effective address exactly like addi in T3/T4
  assign w_addi_like = w_is_imm || w_is_mem;
  assign w_has_t4    = w_is_rtype || w_addi_like || w_is_br;
  assign w_imm_alu   = (w_opcode == c_op_andi) ? c_op_and :
                       (w_opcode == c_op_ori)  ? c_op_or  : c_op_add;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= c_st_rst;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = c_st_rst;
    case (r_state)
      c_st_rst:  w_next = c_st_t0;
      c_st_t0:   w_next = c_st_t1;
      c_st_t1:   w_next = c_st_t2;
      c_st_t2: begin
        if (w_is_halt)                  w_next = c_st_halt;
        else if (w_has_t4 || w_is_jr)   w_next = c_st_t3;
        else                            w_next = c_st_t0;
      end
      c_st_t3:   w_next = w_has_t4 ? c_st_t4 : c_st_t0;
      c_st_t4:   w_next = w_has_t4 ? c_st_t5 : c_st_t0;
      c_st_t5:   w_next = (w_is_mem || w_is_br) ? c_st_t6 : c_st_t0;
      c_st_t6:   w_next = w_is_mem ? c_st_t7 : c_st_t0;
      c_st_t7:   w_next = c_st_t0;
      c_st_halt: w_next = c_st_halt;
      default:   w_next = c_st_rst;
    endcase
  end

  always_comb begin
    R_out = 1'b0; PC_out = 1'b0; MDR_out = 1'b0; Zlo_out = 1'b0; C_out = 1'b0;
    Rin = 1'b0; MARin = 1'b0; Zlowin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; BAout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    op_sel = 5'b00000;
    run = (r_state != c_st_rst) && (r_state != c_st_halt);
    state_view = r_state;
    case (r_state)
      c_st_t0: begin PC_out = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      c_st_t1: begin Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      c_st_t2: begin MDR_out = 1'b1; IRin = 1'b1; end
      c_st_t3: begin
        if (w_is_rtype) begin
          Grb = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (w_addi_like) begin
          Grb = 1'b1; BAout = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (w_is_br) begin
          Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        end else if (w_is_jr) begin
          Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
        end
      end
      c_st_t4: begin
        if (w_is_rtype) begin
          Grc = 1'b1; R_out = 1'b1; Zlowin = 1'b1; op_sel = w_opcode;
        end else if (w_addi_like) begin
          C_out = 1'b1; Zlowin = 1'b1; op_sel = w_imm_alu;
        end else if (w_is_br) begin
          PC_out = 1'b1; Yin = 1'b1;
        end
      end
      c_st_t5: begin
        if (w_is_rtype || w_is_imm) begin
          Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_is_mem) begin
          Zlo_out = 1'b1; MARin = 1'b1;
        end else if (w_is_br) begin
          C_out = 1'b1; Zlowin = 1'b1; op_sel = c_op_add;
        end
      end
      c_st_t6: begin
        if (w_is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (w_is_st) begin
          Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1;
        end else if (w_is_br) begin
          Zlo_out = 1'b1; PCin = con_ff;
        end
      end
      c_st_t7: begin
        if (w_is_ld) begin
          MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_control_sequencer
// Brief   : Self-checking bench comparing the sequencer against an instruction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic R_out, PC_out, MDR_out, Zlo_out, C_out;
  logic Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin;
  logic Gra, Grb, Grc, BAout, IncPC, Read, Write;
  logic [4:0] op_sel;
  logic       run;
  logic [3:0] state_view;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
    .R_out(R_out), .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .C_out(C_out),
    .Rin(Rin), .MARin(MARin), .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .op_sel(op_sel), .run(run), .state_view(state_view)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] M_ROUT   = 20'd1 << 0;
  localparam logic [19:0] M_PCOUT  = 20'd1 << 1;
  localparam logic [19:0] M_MDROUT = 20'd1 << 2;
  localparam logic [19:0] M_ZLOOUT = 20'd1 << 3;
  localparam logic [19:0] M_COUT   = 20'd1 << 4;
  localparam logic [19:0] M_RIN    = 20'd1 << 5;
  localparam logic [19:0] M_MARIN  = 20'd1 << 6;
  localparam logic [19:0] M_ZLOWIN = 20'd1 << 7;
  localparam logic [19:0] M_PCIN   = 20'd1 << 8;
  localparam logic [19:0] M_MDRIN  = 20'd1 << 9;
  localparam logic [19:0] M_IRIN   = 20'd1 << 10;
  localparam logic [19:0] M_YIN    = 20'd1 << 11;
  localparam logic [19:0] M_CONIN  = 20'd1 << 12;
  localparam logic [19:0] M_GRA    = 20'd1 << 13;
  localparam logic [19:0] M_GRB    = 20'd1 << 14;
  localparam logic [19:0] M_GRC    = 20'd1 << 15;
  localparam logic [19:0] M_BAOUT  = 20'd1 << 16;
  localparam logic [19:0] M_INCPC  = 20'd1 << 17;
  localparam logic [19:0] M_READ   = 20'd1 << 18;
  localparam logic [19:0] M_WRITE  = 20'd1 << 19;
  localparam logic [19:0] M_BUS    = M_ROUT | M_PCOUT | M_MDROUT | M_ZLOOUT | M_COUT;
  localparam logic [19:0] M_FETCH0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_HALT = 4'd15;

  typedef struct packed {
    logic [3:0]  st;
    logic        run;
    logic [19:0] ctl;
    logic [4:0]  ops;
  } step_t;

  logic [19:0] w_ctl;
  assign w_ctl = {Write, Read, IncPC, BAout, Grc, Grb, Gra, CONin, Yin, IRin,
                  MDRin, PCin, Zlowin, MARin, Rin, C_out, Zlo_out, MDR_out, PC_out, R_out};

  step_t exp_q[$];
  step_t obs_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic step_t sample();
    step_t s;
    s.st = state_view; s.run = run; s.ctl = w_ctl; s.ops = op_sel;
    return s;
  endfunction

  // push the expected outputs for phase Tt of a running instruction
  task automatic push(input int t, input logic [19:0] ctl, input logic [4:0] ops);
    step_t s;
    s.st = 4'(t + 1); s.run = 1'b1; s.ctl = ctl; s.ops = ops;
    exp_q.push_back(s);
  endtask

  // instruction-level model: micro-operation list per instruction class
  task automatic model(input logic [31:0] iv, input logic cv);
    logic [4:0] op;
    logic [4:0] alu;
    step_t      h;
    op = iv[31:27];
    alu = (op == 5'b01101) ? 5'b00101 : (op == 5'b01110) ? 5'b00110 : 5'b00011;
    exp_q.delete();
    push(0, M_FETCH0, 5'd0);
    push(1, M_ZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(2, M_MDROUT | M_IRIN, 5'd0);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(3, M_GRB | M_ROUT | M_YIN, 5'd0);
        push(4, M_GRC | M_ROUT | M_ZLOWIN, op);
        push(5, M_ZLOOUT | M_GRA | M_RIN, 5'd0);
      end
      5'b01100, 5'b01101, 5'b01110, 5'b00001: begin
        push(3, M_GRB | M_BAOUT | M_ROUT | M_YIN, 5'd0);
        push(4, M_COUT | M_ZLOWIN, alu);
        push(5, M_ZLOOUT | M_GRA | M_RIN, 5'd0);
      end
      5'b00000, 5'b00010: begin
        push(3, M_GRB | M_BAOUT | M_ROUT | M_YIN, 5'd0);
        push(4, M_COUT | M_ZLOWIN, 5'b00011);
        push(5, M_ZLOOUT | M_MARIN, 5'd0);
        if (op == 5'b00000) begin
          push(6, M_READ | M_MDRIN, 5'd0);
          push(7, M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(6, M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(7, M_WRITE, 5'd0);
        end
      end
      5'b10010: begin
        push(3, M_GRA | M_ROUT | M_CONIN, 5'd0);
        push(4, M_PCOUT | M_YIN, 5'd0);
        push(5, M_COUT | M_ZLOWIN, 5'b00011);
        push(6, M_ZLOOUT | (cv ? M_PCIN : 20'd0), 5'd0);
      end
      5'b10100: push(3, M_GRA | M_ROUT | M_PCIN, 5'd0);
      default: ;
    endcase
    if (op == 5'b11010) begin
      h.st = ST_HALT; h.run = 1'b0; h.ctl = 20'd0; h.ops = 5'd0;
      repeat (10) exp_q.push_back(h);
    end else begin
      push(0, M_FETCH0, 5'd0);
    end
  endtask

  // entered and left on a falling edge; records one sample per cycle
  task automatic capture(input logic [31:0] iv, input logic cv);
    int k;
    for (k = 0; k < 20 && state_view != ST_T0; k++) @(negedge clk);
    if (state_view != ST_T0) begin
      n_tests++; n_fail++;
      $display("FAIL sync_t0: state %0d after timeout, want %0d", state_view, ST_T0);
    end
    ir = iv; con_ff = cv;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      obs_q.push_back(sample());
    end
  endtask

  task automatic test_reset();
    step_t z, f, o;
    z = '0;
    f.st = ST_T0; f.run = 1'b1; f.ctl = M_FETCH0; f.ops = 5'd0;
    clr = 1'b0; ir = 32'h0; con_ff = 1'b0;
    #3;
    o = sample(); n_tests++;
    if (o !== z) begin n_fail++; $display("FAIL reset_idle: got %h want %h", o, z); end
    repeat (2) @(posedge clk);
    #1 o = sample(); n_tests++;
    if (o !== z) begin n_fail++; $display("FAIL reset_hold: got %h want %h", o, z); end
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1 o = sample(); n_tests++;
    if (o !== f) begin n_fail++; $display("FAIL reset_to_t0: got %h want %h", o, f); end
    @(negedge clk);
  endtask

  task automatic test_addi();
    model(32'h62B7FFF9, 1'b0);
    capture(32'h62B7FFF9, 1'b0);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL addi step %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ld_st();
    logic [31:0] iv;
    for (int k = 0; k < 2; k++) begin
      iv = {(k == 0) ? 5'b00000 : 5'b00010, 27'($urandom)};
      model(iv, 1'($urandom));
      capture(iv, 1'($urandom));
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s step %0d: got %h want %h", (k == 0) ? "ld" : "st", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_br();
    logic [31:0] iv;
    for (int c = 1; c >= 0; c--) begin
      iv = {5'b10010, 27'($urandom)};
      model(iv, 1'(c));
      capture(iv, 1'(c));
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL br con=%0d step %0d: got %h want %h", c, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] iv;
    for (int op = 3; op <= 6; op++) begin
      iv = {5'(op), 27'($urandom)};
      model(iv, 1'b0);
      capture(iv, 1'b0);
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rtype op=%0d step %0d: got %h want %h", op, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_short_ops();
    logic [4:0]  ops [4] = '{5'b10100, 5'b11001, 5'b01000, 5'b11111};
    logic [31:0] iv;
    foreach (ops[k]) begin
      iv = {ops[k], 27'($urandom)};
      model(iv, 1'b1);
      capture(iv, 1'b1);
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL short op=%b step %0d: got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] iv;
    logic        cv;
    for (int n = 0; n < 60; n++) begin
      iv = $urandom;
      if (iv[31:27] == 5'b11010) iv[31:27] = 5'b11001;
      cv = 1'($urandom_range(0, 1));
      model(iv, cv);
      capture(iv, cv);
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random ir=%h step %0d: got %h want %h", iv, i, obs_q[i], exp_q[i]);
        end
        n_tests++;
        if ((obs_q[i].ctl & (M_READ | M_WRITE)) == (M_READ | M_WRITE) ||
            $countones(obs_q[i].ctl & M_BUS) > 1) begin
          n_fail++;
          $display("FAIL exclusivity ir=%h step %0d: got ctl %h", iv, i, obs_q[i].ctl);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step_t z, f, o;
    int    k;
    z = '0;
    f.st = ST_T0; f.run = 1'b1; f.ctl = M_FETCH0; f.ops = 5'd0;
    for (k = 0; k < 20 && state_view != ST_T0; k++) @(negedge clk);
    ir = {5'b00000, 27'h155};
    repeat (5) @(negedge clk);
    n_tests++;
    if (state_view !== 4'd6) begin n_fail++; $display("FAIL midop_at_t5: got %0d want 6", state_view); end
    #2 clr = 1'b0;
    #1 o = sample(); n_tests++;
    if (o !== z) begin n_fail++; $display("FAIL midop_async_clear: got %h want %h", o, z); end
    @(posedge clk); #1 o = sample(); n_tests++;
    if (o !== z) begin n_fail++; $display("FAIL midop_hold: got %h want %h", o, z); end
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1 o = sample(); n_tests++;
    if (o !== f) begin n_fail++; $display("FAIL midop_restart: got %h want %h", o, f); end
    @(negedge clk);
  endtask

  task automatic test_halt();
    logic [31:0] iv;
    iv = {5'b11010, 27'($urandom)};
    model(iv, 1'b0);
    capture(iv, 1'b0);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL halt step %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ld_st();
    test_br();
    test_rtype();
    test_short_ops();
    test_random();
    test_reset_mid_op();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 clr  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 ir  input  32  instruction register contents; opcode = ir[31:27].
REQ-004 con_ff  input  1  branch-condition flag from datapath, sampled in branch T6.
REQ-005 Outputs, each 1 bit, active-high, driven to the datapath:
- Bus sources: R_out, PC_out, MDR_out, Zlo_out, C_out.
- Load enables: Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, CONin.
- Register select: Gra, Grb, Grc, BAout.
- Memory and PC: IncPC, Read, Write.
REQ-006 op_sel  output  5  ALU operation select.
REQ-007 run  output  1  high while sequencing; low in IDLE-after-reset and HALT.
REQ-008 state_view  output  4  current state encoding, for debug.

Function
REQ-009 The block SHALL be a Moore FSM: every output SHALL be a combinational decode of the state register and ir only; each state SHALL last exactly one clk cycle.
REQ-010 States SHALL be RST, T0..T7, HALT; control signals not listed for a state SHALL be 0 and op_sel SHALL be 5'b00000.
REQ-011 Fetch, common to all opcodes:
- T0: PC_out, MARin, IncPC, Zlowin.
- T1: Zlo_out, PCin, Read, MDRin.
- T2: MDR_out, IRin.
REQ-012 Opcode SHALL be decoded from ir during T3 onward; ir loaded in T2 SHALL be visible from T3.
REQ-013 R-type ALU (add 00011, sub 00100, and 00101, or 00110):
- T3: Grb, R_out, Yin.
- T4: Grc, R_out, Zlowin, op_sel = opcode.
- T5: Zlo_out, Gra, Rin, then T0.
REQ-014 Immediate (addi 01100, andi 01101, ori 01110):
- T3: Grb, BAout, R_out, Yin.
- T4: C_out, Zlowin, op_sel = 00011 / 00101 / 00110 respectively.
- T5: Zlo_out, Gra, Rin, then T0.
REQ-015 ldi 00001: T3-T5 as addi, then T0.
REQ-016 ld 00000:
- T3-T4 as addi.
- T5: Zlo_out, MARin.
- T6: Read, MDRin.
- T7: MDR_out, Gra, Rin, then T0.
REQ-017 st 00010:
- T3-T5 as ld.
- T6: Gra, R_out, MDRin, with Read = 0.
- T7: Write, then T0.
REQ-018 br 10010:
- T3: Gra, R_out, CONin.
- T4: PC_out, Yin.
- T5: C_out, Zlowin, op_sel = 00011.
- T6: Zlo_out, PCin = con_ff, then T0.
REQ-019 jr 10100: T3: Gra, R_out, PCin, then T0.
REQ-020 nop 11001 and every undefined opcode SHALL go from T2 directly to T0.
REQ-021 halt 11010 SHALL go from T2 to HALT.
- HALT SHALL hold with all controls 0 and run = 0 until reset.
REQ-022 Read and Write SHALL never be asserted in the same state.
REQ-023 At most one bus source (R_out, PC_out, MDR_out, Zlo_out, C_out) SHALL be asserted in any state.

Reset
REQ-024 clr low SHALL force state RST immediately, asynchronously and independent of clk, including mid-instruction.
REQ-025 In RST all control outputs and run SHALL be 0 and op_sel SHALL be 00000.
REQ-026 After clr rises, RST SHALL advance to T0 on the first rising clk edge with clr high; run SHALL be 1 from T0.
REQ-027 A partially executed instruction SHALL be abandoned on reset, with no further Rin, PCin or Write.

Verification
REQ-028 addi, ir = 0x62B7FFF9 (opcode 01100): states SHALL follow T0, T1, T2, T3, T4, T5, T0.
- T3 SHALL assert Grb, BAout, R_out, Yin.
- T4 SHALL assert C_out and Zlowin with op_sel = 00011.
- T5 SHALL assert Zlo_out, Gra, Rin.
REQ-029 ld, opcode 00000: 8 cycles T0-T7.
- Read SHALL be high only in T1 and T6.
- Rin SHALL be high only in T7.
REQ-030 st, opcode 00010: Write SHALL be high only in T7, and MDRin SHALL be high in T1 and T6.
REQ-031 br, opcode 10010:
- With con_ff = 1, PCin SHALL be high in T6.
- With con_ff = 0, PCin SHALL be low in T6.
- Both cases SHALL return to T0.
REQ-032 halt, opcode 11010: T2 SHALL go to HALT with run = 0, and the block SHALL stay there for 10 cycles.
REQ-033 Reset mid-op: pull clr low in ld T5 between clock edges.
- All outputs SHALL go to 0 immediately.
- After release, the first edge SHALL give T0 with PC_out, MARin, IncPC, Zlowin high.
